// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
// Optional forwarding port set is enabled with RFWS_FWD_EN.
package rfws_pkg;

  localparam int RFWS_AW = 5;
  localparam int RFWS_DW = 32;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic               valid;
    logic [RFWS_AW-1:0] addr;
    logic [RFWS_DW-1:0] data;
  } wb_req_t;

  // A request is worth queueing only if valid and not aimed at $zero.
  function automatic logic keep_req(
    input logic        v,
    input logic [31:0] a
  );
    return v && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback-lane and register-file port bundle for the scheduler.
// Forwarding signals exist only when RFWS_FWD_EN is defined.
interface regfile_write_scheduler_if
  import rfws_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RFWS_AW,
  parameter int DW    = RFWS_DW
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in0_valid;
  logic [AW-1:0] in0_addr;
  logic [DW-1:0] in0_data;
  logic          in1_valid;
  logic [AW-1:0] in1_addr;
  logic [DW-1:0] in1_data;
  logic          in_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] count;
  logic          empty;
`ifdef RFWS_FWD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

`ifdef RFWS_FWD_EN
  modport master (
    output in0_valid, in0_addr, in0_data,
    output in1_valid, in1_addr, in1_data,
    output fwd_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  count, empty, fwd_hit, fwd_data
  );

  modport slave (
    input  in0_valid, in0_addr, in0_data,
    input  in1_valid, in1_addr, in1_data,
    input  fwd_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output count, empty, fwd_hit, fwd_data
  );
`else
  modport master (
    output in0_valid, in0_addr, in0_data,
    output in1_valid, in1_addr, in1_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  count, empty
  );

  modport slave (
    input  in0_valid, in0_addr, in0_data,
    input  in1_valid, in1_addr, in1_data,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output count, empty
  );
`endif

endinterface

// File: rtl/regfile_write_scheduler_youngest_match.sv
// Backward priority search for the youngest queued write to an address.
// Instantiated by the scheduler only when RFWS_FWD_EN is defined.
module rfws_youngest_match
  import rfws_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RFWS_AW,
  parameter int DW    = RFWS_DW,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [PW-1:0]              wr_ptr,
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][AW-1:0]   addr,
  input  logic [DEPTH-1:0][DW-1:0]   data,
  input  logic [AW-1:0]              query,
  output logic                       hit,
  output logic [DW-1:0]              hit_data
);

  logic          query_nz;
  logic [PW-1:0] idx;

  assign query_nz = (32'(query) != REG_ZERO);

  // Walk oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wr_ptr - PW'(i);
      if (query_nz && valid[idx] && (addr[idx] == query)) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Two-lane writeback queue draining one write per cycle into the RF.
// Define RFWS_FWD_EN to add the pending-write forwarding lookup.
module regfile_write_scheduler
  import rfws_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RFWS_AW,
  parameter int DW    = RFWS_DW
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      flush,
  input  logic                      hold,
  regfile_write_scheduler_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic          in_ready;
  logic          keep0, keep1;
  logic          pop;
  logic [PW-1:0] wr_ptr_n1;
  entry_t        head;
  entry_t        ent0, ent1;

  // Admission, filtering and drain decode from registered state.
  always_comb begin
    in_ready  = (cnt_q <= CW'(DEPTH - 2));
    keep0     = in_ready
              && keep_req(bus.in0_valid, 32'(bus.in0_addr));
    keep1     = in_ready
              && keep_req(bus.in1_valid, 32'(bus.in1_addr));
    pop       = (cnt_q != '0) && !hold;
    head      = mem_q[rd_ptr_q];
    wr_ptr_n1 = wr_ptr_q + PW'(1);
    ent0      = '{valid: 1'b1,
                  addr:  bus.in0_addr,
                  data:  bus.in0_data};
    ent1      = '{valid: 1'b1,
                  addr:  bus.in1_addr,
                  data:  bus.in1_data};
  end

  assign bus.in_ready = in_ready;
  assign bus.rf_we    = pop;
  assign bus.rf_waddr = pop ? head.addr : '0;
  assign bus.rf_wdata = pop ? head.data : '0;
  assign bus.count    = cnt_q;
  assign bus.empty    = (cnt_q == '0);

  // Next queue state: flush clears everything, else pop then push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].valid = 1'b0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop) begin
        mem_d[rd_ptr_q].valid = 1'b0;
        rd_ptr_d              = rd_ptr_q + PW'(1);
      end
      unique case (1'b1)
        keep0 && keep1: begin
          mem_d[wr_ptr_q]  = ent0;
          mem_d[wr_ptr_n1] = ent1;
          wr_ptr_d         = wr_ptr_q + PW'(2);
        end
        keep0 && !keep1: begin
          mem_d[wr_ptr_q] = ent0;
          wr_ptr_d        = wr_ptr_n1;
        end
        !keep0 && keep1: begin
          mem_d[wr_ptr_q] = ent1;
          wr_ptr_d        = wr_ptr_n1;
        end
        default: ;
      endcase
      cnt_d = cnt_q + CW'(keep0) + CW'(keep1) - CW'(pop);
    end
  end

  // Queue state registers; reset discards every pending write.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef RFWS_FWD_EN
  logic [DEPTH-1:0]         fwd_v;
  logic [DEPTH-1:0][AW-1:0] fwd_a;
  logic [DEPTH-1:0][DW-1:0] fwd_d;

  // Unpack queue entries into per-field vectors for the search.
  always_comb begin
    fwd_v = '0;
    fwd_a = '0;
    fwd_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_v[i] = mem_q[i].valid;
      fwd_a[i] = mem_q[i].addr;
      fwd_d[i] = mem_q[i].data;
    end
  end

  rfws_youngest_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match (
    .wr_ptr   (wr_ptr_q),
    .valid    (fwd_v),
    .addr     (fwd_a),
    .data     (fwd_d),
    .query    (bus.fwd_addr),
    .hit      (bus.fwd_hit),
    .hit_data (bus.fwd_data)
  );
`endif

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Sequences writebacks from the two superscalar issue lanes into the register file's single write port.
- Accepts up to two writes per cycle into an ordered queue and drains exactly one write per cycle.
- Program order is preserved: lane0 is older than lane1 within a cycle.
- Sits between the two writeback stages and the register file's write_enable/data_in/address port.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock, rising edge
areset  in  1  asynchronous reset, active-low (0 = reset)
flush  in  1  synchronous queue clear (pipeline squash)
hold  in  1  suppress drain this cycle (e.g. during register aload)
in0_valid  in  1  lane0 write request (older)
in0_addr  in  AW  lane0 destination register
in0_data  in  DW  lane0 write data
in1_valid  in  1  lane1 write request (younger)
in1_addr  in  AW  lane1 destination register
in1_data  in  DW  lane1 write data
in_ready  out  1  both lanes may push this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data
count  out  $clog2(DEPTH)+1  current occupancy
empty  out  1  count == 0

Behaviour:
- Reset (areset=0, asynchronous):
  - rd/wr pointers=0, count=0, all entries invalid.
  - empty=1, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0.
  - Reset mid-operation discards all queued writes; none reach the register file.
- in_ready = (DEPTH - count) >= 2. It is computed from registered count and ignores a same-cycle pop (conservative).
- Pushes are accepted only when in_ready=1. A valid input while in_ready=0 is a protocol violation; the bench asserts it never happens, and the RTL ignores the write.
- Filtering: a request with addr==0 is dropped and never enqueued ($zero is never written).
- Enqueue order per cycle:
  - Both lanes kept: lane0 at wr_ptr, lane1 at wr_ptr+1, wr_ptr += 2.
  - One lane kept: it goes at wr_ptr, wr_ptr += 1.
- Drain: rf_we = !empty && !hold. When rf_we=1, rf_waddr/rf_wdata = head entry; otherwise both are driven 0.
  - Outputs decode from registered state only (no input-to-output path).
  - The pop commits at the same clock edge at which the register file latches.
- Latency: a write pushed at edge N into an empty queue presents on rf_* during cycle N+1 and commits at edge N+1.
- Push and pop in the same cycle are legal: count_next = count + pushes - pop.
- Pointers wrap modulo DEPTH.
- Same-address writes drain in queue order, so the younger value commits last.
- flush=1: pointers and count clear at the edge; the same cycle's pushes are discarded (flush wins); rf_we still reflects the pre-flush head for that cycle.
- hold=1 with flush=1: flush wins.

Optional Feature:
RFWS_FWD_EN
- Defined: adds ports fwd_addr (in, AW), fwd_hit (out, 1) and fwd_data (out, DW), all combinational.
  - fwd_hit=1 when any queued entry matches fwd_addr != 0.
  - fwd_data = the youngest matching entry, giving the read stage a bypass for pending writes.
  - With no match, fwd_hit=0 and fwd_data=0.
- Undefined: these ports are absent, and the read stage must stall until empty=1.

Decomposition:
- Shared package rfws_pkg holds:
  - wb_req_t struct {valid, addr[AW], data[DW]};
  - constant REG_ZERO=0;
  - default AW/DW constants shared with the register file.
- One natural sub-module, rfws_youngest_match: a priority search from wr_ptr-1 backward for the forwarding lookup. It is instantiated only under RFWS_FWD_EN.

Test Plan:
- Reset mid-drain: queue 3 entries, pulse areset=0 -> immediately rf_we=0, count=0, in_ready=1; no further register writes occur.
- Dual push into empty queue: in0 (r3,0x11), in1 (r3,0x22) at edge N -> r3 written with 0x11 at edge N+1, then 0x22 at edge N+2; final r3=0x22.
- $zero filter: in0 (r0,0xFF), in1 (r5,0xAB) -> count goes to 1 only; only r5=0xAB is written; r0 is never driven.
- Full boundary with DEPTH=4: push 2, push 2 under hold=1 -> count=4, in_ready=0. Release hold -> 4 writes over 4 cycles in order; in_ready returns when count=2.
- Flush vs push: count=2, same cycle flush=1 with in0 (r7,0x5) -> after the edge count=0, r7 is never written.
- Forwarding, under RFWS_FWD_EN: queue (r9,0x1) then (r9,0x2), fwd_addr=9 -> fwd_hit=1, fwd_data=0x2. fwd_addr=4 -> fwd_hit=0.
